// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode/funct encodings, ALU and writeback selectors for the single-cycle core
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_PASS_B
  } alu_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  function automatic alu_op_e alu_op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_XOR:  return ALU_XOR;
      F3_SRL:  return ALU_SRL;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: word-addressed data RAM, combinational read, clocked write, not cleared by reset
module riscv_data_mem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [29:0] word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = DMEM_WORDS > 1 ? $clog2(DMEM_WORDS) : 1;
  logic [31:0] memory [0:DMEM_WORDS-1];
  logic [AW-1:0] idx;
  initial for (int i = 0; i < DMEM_WORDS; i++) memory[i] = '0;
  assign idx = AW'(word_addr % 30'(DMEM_WORDS));
  assign rdata = memory[idx];
  always_ff @(posedge clk)
    if (we) memory[idx] <= wdata;
endmodule

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 register file, two combinational reads, one synchronous write, x0 hardwired to 0
module riscv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_we,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] registers [0:31];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 32; i++) registers[i] <= '0;
    else if (rd_we && rd_addr != 5'd0) registers[rd_addr] <= rd_data;
  assign rs1_data = registers[rs1_addr];
  assign rs2_data = registers[rs2_addr];
endmodule

// File: rtl/riscv_single_cycle_top.sv
// riscv_single_cycle_top: single-cycle RV32I-subset core committing one instruction per clock
module riscv_single_cycle_top
  import riscv_pkg::*;
#(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_FILE  = "program.hex"
) (
  input logic clk,
  input logic rst
);
  localparam int IW = IMEM_WORDS > 1 ? $clog2(IMEM_WORDS) : 1;
  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rs1_data, rs2_data, alu_b, alu_res, mem_rdata, rd_data;
  logic        rd_we, mem_we, r_legal, i_legal;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  assign pc_plus4 = pc_q + 32'd4;
  assign instr = pc_q[31:2] < 30'(IMEM_WORDS) ? imem[pc_q[IW+1:2]] : NOP;
  assign {funct7, rs2, rs1, funct3, rd, opcode} = instr;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign r_legal = (funct7 == F7_BASE) ? (funct3 != F3_SLTU) : (funct7 == F7_ALT && funct3 == F3_ADD);
  assign i_legal = (funct3 == F3_SLL || funct3 == F3_SRL) ? (funct7 == F7_BASE)
                                                          : (funct3 != F3_SLT && funct3 != F3_SLTU);
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_i;
    rd_we  = 1'b0;
    mem_we = 1'b0;
    wb_sel = WB_ALU;
    pc_d   = pc_plus4;
    case (opcode)
      OP_R: begin
        alu_op = alu_op_of(funct3, funct7[5]);
        alu_b  = rs2_data;
        rd_we  = r_legal;
      end
      OP_I: begin
        alu_op = alu_op_of(funct3, 1'b0);
        rd_we  = i_legal;
      end
      OP_LOAD: begin
        wb_sel = WB_MEM;
        rd_we  = funct3 == F3_WORD;
      end
      OP_STORE: begin
        alu_b  = imm_s;
        mem_we = funct3 == F3_WORD;
      end
      OP_BRANCH:
        if ((funct3 == F3_BEQ && rs1_data == rs2_data) || (funct3 == F3_BNE && rs1_data != rs2_data))
          pc_d = pc_q + imm_b;
      OP_JAL: begin
        wb_sel = WB_PC4;
        rd_we  = 1'b1;
        pc_d   = pc_q + imm_j;
      end
      OP_LUI: begin
        alu_op = ALU_PASS_B;
        alu_b  = imm_u;
        rd_we  = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = rs1_data + alu_b;
      ALU_SUB: alu_res = rs1_data - alu_b;
      ALU_AND: alu_res = rs1_data & alu_b;
      ALU_OR:  alu_res = rs1_data | alu_b;
      ALU_XOR: alu_res = rs1_data ^ alu_b;
      ALU_SLL: alu_res = rs1_data << alu_b[4:0];
      ALU_SRL: alu_res = rs1_data >> alu_b[4:0];
      ALU_SLT: alu_res = {31'b0, $signed(rs1_data) < $signed(alu_b)};
      default: alu_res = alu_b;
    endcase
  end
  assign rd_data = wb_sel == WB_MEM ? mem_rdata : wb_sel == WB_PC4 ? pc_plus4 : alu_res;
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= '0;
    else pc_q <= pc_d;
  riscv_regfile rf (
    .clk(clk),
    .rst(rst),
    .rs1_addr(rs1),
    .rs2_addr(rs2),
    .rd_addr(rd),
    .rd_we(rd_we),
    .rd_data(rd_data),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data)
  );
  riscv_data_mem #(.DMEM_WORDS(DMEM_WORDS)) dmem (
    .clk(clk),
    .we(mem_we),
    .word_addr(alu_res[31:2]),
    .wdata(rs2_data),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_riscv_single_cycle_top.sv
// tb_riscv_single_cycle_top: directed and random programs checked against an instruction-level model
module tb_riscv_single_cycle_top;
  typedef enum {
    I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SLT,
    I_ADDI, I_ANDI, I_ORI, I_XORI, I_SLLI, I_SRLI,
    I_LW, I_SW, I_BEQ, I_BNE, I_JAL, I_LUI, I_BAD
  } op_t;
  typedef struct {
    op_t         op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } ins_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  ins_t prog [64];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  riscv_single_cycle_top #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("")) dut (
    .clk(clk),
    .rst(rst)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic ins_t mk(input op_t op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    ins_t t;
    t.op = op;
    t.rd = 5'(rd);
    t.rs1 = 5'(rs1);
    t.rs2 = 5'(rs2);
    t.imm = imm;
    return t;
  endfunction
  function automatic logic [31:0] enc(input ins_t t);
    logic [31:0] m;
    m = t.imm;
    case (t.op)
      I_ADD:  return {7'h00, t.rs2, t.rs1, 3'd0, t.rd, 7'h33};
      I_SUB:  return {7'h20, t.rs2, t.rs1, 3'd0, t.rd, 7'h33};
      I_SLL:  return {7'h00, t.rs2, t.rs1, 3'd1, t.rd, 7'h33};
      I_SLT:  return {7'h00, t.rs2, t.rs1, 3'd2, t.rd, 7'h33};
      I_XOR:  return {7'h00, t.rs2, t.rs1, 3'd4, t.rd, 7'h33};
      I_SRL:  return {7'h00, t.rs2, t.rs1, 3'd5, t.rd, 7'h33};
      I_OR:   return {7'h00, t.rs2, t.rs1, 3'd6, t.rd, 7'h33};
      I_AND:  return {7'h00, t.rs2, t.rs1, 3'd7, t.rd, 7'h33};
      I_ADDI: return {m[11:0], t.rs1, 3'd0, t.rd, 7'h13};
      I_XORI: return {m[11:0], t.rs1, 3'd4, t.rd, 7'h13};
      I_ORI:  return {m[11:0], t.rs1, 3'd6, t.rd, 7'h13};
      I_ANDI: return {m[11:0], t.rs1, 3'd7, t.rd, 7'h13};
      I_SLLI: return {7'h00, m[4:0], t.rs1, 3'd1, t.rd, 7'h13};
      I_SRLI: return {7'h00, m[4:0], t.rs1, 3'd5, t.rd, 7'h13};
      I_LW:   return {m[11:0], t.rs1, 3'd2, t.rd, 7'h03};
      I_SW:   return {m[11:5], t.rs2, t.rs1, 3'd2, m[4:0], 7'h23};
      I_BEQ:  return {m[12], m[10:5], t.rs2, t.rs1, 3'd0, m[4:1], m[11], 7'h63};
      I_BNE:  return {m[12], m[10:5], t.rs2, t.rs1, 3'd1, m[4:1], m[11], 7'h63};
      I_JAL:  return {m[20], m[10:1], m[11], m[19:12], t.rd, 7'h6f};
      I_LUI:  return {m[31:12], t.rd, 7'h37};
      default: return m;
    endcase
  endfunction
  task automatic m_step();
    ins_t t;
    logic [31:0] a, b, r, npc;
    logic w;
    int idx;
    idx = int'(m_pc >> 2);
    t = idx < 64 ? prog[idx] : mk(I_ADDI, 0, 0, 0, 0);
    a = m_reg[t.rs1];
    b = m_reg[t.rs2];
    r = '0;
    w = 1'b1;
    npc = m_pc + 4;
    case (t.op)
      I_ADD:  r = a + b;
      I_SUB:  r = a - b;
      I_AND:  r = a & b;
      I_OR:   r = a | b;
      I_XOR:  r = a ^ b;
      I_SLL:  r = a << b[4:0];
      I_SRL:  r = a >> b[4:0];
      I_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      I_ADDI: r = a + t.imm;
      I_ANDI: r = a & t.imm;
      I_ORI:  r = a | t.imm;
      I_XORI: r = a ^ t.imm;
      I_SLLI: r = a << t.imm[4:0];
      I_SRLI: r = a >> t.imm[4:0];
      I_LW:   r = m_mem[int'(((a + t.imm) >> 2) % 64)];
      I_SW: begin
        w = 1'b0;
        m_mem[int'(((a + t.imm) >> 2) % 64)] = b;
      end
      I_BEQ: begin
        w = 1'b0;
        if (a == b) npc = m_pc + t.imm;
      end
      I_BNE: begin
        w = 1'b0;
        if (a != b) npc = m_pc + t.imm;
      end
      I_JAL: begin
        r = m_pc + 4;
        npc = m_pc + t.imm;
      end
      I_LUI:  r = t.imm;
      default: w = 1'b0;
    endcase
    if (w && t.rd != 5'd0) m_reg[t.rd] = r;
    m_pc = npc;
  endtask
  function automatic ins_t rand_ins();
    logic [31:0] si, w;
    int rd, rs1, rs2, k;
    op_t r_ops [8] = '{I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SLT};
    op_t i_ops [4] = '{I_ADDI, I_ANDI, I_ORI, I_XORI};
    rd = $urandom_range(0, 15);
    rs1 = $urandom_range(0, 15);
    rs2 = $urandom_range(0, 15);
    si = $urandom_range(0, 4095) - 2048;
    k = $urandom_range(0, 20);
    if (k < 8) return mk(r_ops[k], rd, rs1, rs2, 0);
    if (k < 12) return mk(i_ops[k-8], rd, rs1, 0, si);
    case (k)
      12: return mk(I_SLLI, rd, rs1, 0, $urandom_range(0, 31));
      13: return mk(I_SRLI, rd, rs1, 0, $urandom_range(0, 31));
      14: return mk(I_LW, rd, rs1, 0, si);
      15: return mk(I_SW, 0, rs1, rs2, si);
      16: return mk(I_BEQ, 0, $urandom_range(0, 3), $urandom_range(0, 3), 4 * $urandom_range(2, 4));
      17: return mk(I_BNE, 0, $urandom_range(0, 3), $urandom_range(0, 3), 4 * $urandom_range(2, 4));
      18: return mk(I_JAL, rd, 0, 0, 4 * $urandom_range(2, 4));
      19: return mk(I_LUI, rd, 0, 0, $urandom() & 32'hFFFF_F000);
      default: begin
        w = $urandom();
        case ($urandom_range(0, 9))
          0: begin w[6:0] = 7'h33; w[14:12] = 3'd3; w[31:25] = 7'h00; end
          1: begin w[6:0] = 7'h33; w[14:12] = 3'd5; w[31:25] = 7'h20; end
          2: begin w[6:0] = 7'h13; w[14:12] = 3'd2; end
          3: begin w[6:0] = 7'h13; w[14:12] = 3'd5; w[31:25] = 7'h20; end
          4: begin w[6:0] = 7'h03; w[14:12] = 3'd0; end
          5: begin w[6:0] = 7'h23; w[14:12] = 3'd1; end
          6: w[6:0] = 7'h67;
          7: begin w[6:0] = 7'h63; w[14:12] = 3'd4; end
          8: w[6:0] = 7'h17;
          default: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
        endcase
        return mk(I_BAD, 0, 0, 0, w);
      end
    endcase
  endfunction
  task automatic load_imem();
    for (int i = 0; i < 64; i++) dut.imem[i] = enc(prog[i]);
  endtask
  task automatic model_reset();
    m_pc = '0;
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
  endtask
  task automatic check_reset(input string ph);
    check({ph, " rst pc"}, dut.pc_q, 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("%s rst x%0d", ph, r), dut.rf.registers[r], 32'd0);
  endtask
  task automatic run(input int n, input string ph);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      m_step();
      @(negedge clk);
      check($sformatf("%s c%0d pc", ph, c), dut.pc_q, m_pc);
      for (int r = 0; r < 32; r++) check($sformatf("%s c%0d x%0d", ph, c, r), dut.rf.registers[r], m_reg[r]);
    end
  endtask
  task automatic check_mem(input string ph);
    for (int i = 0; i < 64; i++) check($sformatf("%s mem[%0d]", ph, i), dut.dmem.memory[i], m_mem[i]);
  endtask
  initial begin
    int exp_d [11] = '{0, 10, 3, 13, 7, 2, 11, 9, 13, 0, 7};
    for (int i = 0; i < 64; i++) begin
      prog[i] = mk(I_ADDI, 0, 0, 0, 0);
      m_mem[i] = '0;
    end
    prog[0]  = mk(I_ADDI, 1, 0, 0, 10);
    prog[1]  = mk(I_ADDI, 2, 0, 0, 3);
    prog[2]  = mk(I_ADD, 3, 1, 2, 0);
    prog[3]  = mk(I_SUB, 4, 1, 2, 0);
    prog[4]  = mk(I_AND, 5, 1, 2, 0);
    prog[5]  = mk(I_OR, 6, 1, 2, 0);
    prog[6]  = mk(I_XOR, 7, 1, 2, 0);
    prog[7]  = mk(I_SW, 0, 0, 3, 8);
    prog[8]  = mk(I_LW, 8, 0, 0, 8);
    prog[9]  = mk(I_ADDI, 0, 0, 0, 5);
    prog[10] = mk(I_BEQ, 0, 1, 1, 8);
    prog[11] = mk(I_ADDI, 9, 0, 0, 1);
    prog[12] = mk(I_BNE, 0, 1, 1, 8);
    prog[13] = mk(I_ADDI, 10, 0, 0, 7);
    prog[14] = mk(I_BEQ, 0, 0, 0, 0);
    load_imem();
    model_reset();
    #12;
    check_reset("init");
    #8;
    rst = 1'b0;
    run(1, "dir");
    check("dir first x1", dut.rf.registers[1], 32'd10);
    check("dir first pc", dut.pc_q, 32'd4);
    run(29, "dir");
    for (int r = 0; r < 11; r++) check($sformatf("dir const x%0d", r), dut.rf.registers[r], exp_d[r]);
    check("dir halt pc", dut.pc_q, 32'd56);
    check("dir mem[2]", dut.dmem.memory[2], 32'd13);
    check_mem("dir");
    for (int it = 0; it < 3; it++) begin
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_reset($sformatf("rnd%0d", it));
      for (int i = 0; i < 64; i++) prog[i] = mk(I_ADDI, 0, 0, 0, 0);
      for (int i = 0; i < 48; i++) prog[i] = rand_ins();
      prog[48] = mk(I_BEQ, 0, 0, 0, 0);
      load_imem();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      run(it == 0 ? 20 : 70, $sformatf("rnd%0d", it));
    end
    check_mem("end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
